// File: rtl/pulse_handshake_queue.sv
// Turns single-cycle event pulses into back-to-back four-phase req/ack transactions.
// Pulses that arrive during a transaction are queued, and a sticky flag records any pulse lost at saturation.
module pulse_handshake_queue #(
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk_slow,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack,
  output logic             req,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  logic [1:0]       state_reg,    state_next;
  logic [7:0]       gap_cnt_reg,  gap_cnt_next;
  logic [CNT_W-1:0] pending_reg,  pending_next;
  logic             overflow_reg, overflow_next;
  logic             req_reg;
  logic             inc, dec, drop;

  // Handshake sequencer
  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        // Holding off while ack is high keeps a stale ack from a reset mid-transaction out of the next cycle
        if ((pending_reg != '0) && !ack) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack) begin
          if (GAP > 0) begin
            state_next   = S_GAP;
            gap_cnt_next = GAP_LOAD;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Pending-event counter and loss detection
  assign inc = pulse_in;
  assign dec = (state_reg == S_REQ) && ack;

  always_comb begin
    pending_next = pending_reg;
    drop         = 1'b0;
    if (inc && !dec) begin
      if (pending_reg == CNT_MAX) begin
        drop = 1'b1;
      end else begin
        pending_next = pending_reg + CNT_ONE;
      end
    end else if (dec && !inc) begin
      pending_next = pending_reg - CNT_ONE;
    end
  end

  // A drop on the same edge as a clear must leave the flag set
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk_slow) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      gap_cnt_reg  <= 8'd0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      req_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gap_cnt_reg  <= gap_cnt_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      req_reg      <= (state_next == S_REQ);
    end
  end

  assign req      = req_reg;
  assign pending  = pending_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pulse_handshake_queue.sv
// Directed-vector bench: dut_a (CNT_W=2, GAP=2) covers most behaviour, dut_b (CNT_W=4, GAP=0) covers zero gap.
module tb_pulse_handshake_queue;

  logic       clk_slow = 1'b0;
  logic       rst      = 1'b1;
  logic       pulse_in = 1'b0;
  logic       ack      = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic       req_a, overflow_a, busy_a;
  logic [1:0] pending_a;
  logic       req_b, overflow_b, busy_b;
  logic [3:0] pending_b;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  auto_en = 1'b0;
  bit  req_d = 1'b0;
  int  first_req, busy_cnt, rises, low_run;
  bit  prev_req;

  always #5 clk_slow = ~clk_slow;

  pulse_handshake_queue #(.CNT_W(2), .GAP(2)) dut_a (
    .clk_slow(clk_slow), .rst(rst), .pulse_in(pulse_in), .ack(ack),
    .req(req_a), .pending(pending_a), .overflow(overflow_a),
    .ovf_clr(ovf_clr), .busy(busy_a)
  );

  pulse_handshake_queue #(.CNT_W(4), .GAP(0)) dut_b (
    .clk_slow(clk_slow), .rst(rst), .pulse_in(pulse_in), .ack(ack),
    .req(req_b), .pending(pending_b), .overflow(overflow_b),
    .ovf_clr(ovf_clr), .busy(busy_b)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one edge; the optional responder raises ack one cycle after req and drops it as soon as req falls
  task automatic tick();
    @(posedge clk_slow);
    #1;
    if (auto_en) begin
      if (!req_a) ack = 1'b0;
      else if (req_d) ack = 1'b1;
      req_d = req_a;
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check_vec("rst_req", req_a, 0);
    check_vec("rst_pending", pending_a, 0);
    check_vec("rst_overflow", overflow_a, 0);
    check_vec("rst_busy", busy_a, 0);
    check_vec("rst_b_pending", pending_b, 0);

    // Single pulse, responder on
    auto_en = 1'b1; req_d = 1'b0;
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    check_vec("single_pending_up", pending_a, 1);
    first_req = -1; busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_a) busy_cnt++;
      if (req_a && first_req < 0) first_req = i + 2;
    end
    check_vec("single_req_latency", first_req, 2);
    check_vec("single_busy_cycles", busy_cnt, 5);
    check_vec("single_pending_down", pending_a, 0);
    check_vec("single_overflow", overflow_a, 0);

    // Burst of three with ack held low
    auto_en = 1'b0; ack = 1'b0;
    pulse_in = 1'b1; tick(); tick(); tick(); pulse_in = 1'b0;
    check_vec("burst_pending", pending_a, 3);
    check_vec("burst_req_held", req_a, 1);
    auto_en = 1'b1; req_d = 1'b0;
    rises = 1; low_run = 0; prev_req = req_a;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_a) begin
        if (!prev_req) begin
          rises++;
          check_vec("burst_spacing", low_run, 4);
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = req_a;
    end
    check_vec("burst_transactions", rises, 3);
    check_vec("burst_pending_end", pending_a, 0);
    check_vec("burst_busy_end", busy_a, 0);

    // Saturation at CNT_W=2 with ack stuck low
    auto_en = 1'b0; ack = 1'b0;
    pulse_in = 1'b1; tick(); tick(); tick(); pulse_in = 1'b0;
    check_vec("sat_pending3", pending_a, 3);
    check_vec("sat_no_ovf", overflow_a, 0);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    check_vec("sat_hold", pending_a, 3);
    check_vec("sat_ovf_set", overflow_a, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check_vec("sat_ovf_clr", overflow_a, 0);
    pulse_in = 1'b1; ovf_clr = 1'b1; tick(); pulse_in = 1'b0; ovf_clr = 1'b0;
    check_vec("sat_set_beats_clr", overflow_a, 1);
    check_vec("sat_hold2", pending_a, 3);

    // Pulse coinciding with the decrement
    rst = 1'b1; tick(); rst = 1'b0;
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    tick();
    check_vec("coin_in_req", req_a, 1);
    pulse_in = 1'b1; ack = 1'b1; tick(); pulse_in = 1'b0; ack = 1'b0;
    check_vec("coin_pending", pending_a, 1);
    check_vec("coin_req_low", req_a, 0);
    tick();
    auto_en = 1'b1; req_d = 1'b0;
    rises = 0; prev_req = req_a;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_a && !prev_req) rises++;
      prev_req = req_a;
    end
    check_vec("coin_second_txn", rises, 1);
    check_vec("coin_pending_end", pending_a, 0);

    // Reset mid-handshake with ack high
    auto_en = 1'b0; ack = 1'b0;
    pulse_in = 1'b1; tick(); tick(); pulse_in = 1'b0;
    check_vec("midrst_pending2", pending_a, 2);
    check_vec("midrst_in_req", req_a, 1);
    ack = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    check_vec("midrst_req", req_a, 0);
    check_vec("midrst_pending", pending_a, 0);
    check_vec("midrst_busy", busy_a, 0);
    pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    check_vec("stale_ack_pending", pending_a, 1);
    check_vec("stale_ack_req0", req_a, 0);
    tick();
    check_vec("stale_ack_req1", req_a, 0);
    tick();
    check_vec("stale_ack_req2", req_a, 0);
    ack = 1'b0; tick();
    check_vec("stale_ack_release", req_a, 1);

    // GAP=0 on dut_b with two queued events
    rst = 1'b1; tick(); rst = 1'b0;
    pulse_in = 1'b1; tick(); tick(); pulse_in = 1'b0;
    check_vec("gap0_pending2", pending_b, 2);
    check_vec("gap0_req_first", req_b, 1);
    ack = 1'b1; tick();
    check_vec("gap0_dec", pending_b, 1);
    check_vec("gap0_req_fall", req_b, 0);
    ack = 1'b0; tick();
    check_vec("gap0_idle_req", req_b, 0);
    tick();
    check_vec("gap0_second_req", req_b, 1);
    ack = 1'b1; tick(); ack = 1'b0; tick(); tick();
    check_vec("gap0_pending_end", pending_b, 0);
    check_vec("gap0_busy_end", busy_b, 0);
    check_vec("gap0_overflow", overflow_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
